interface_spimaster: RTL and testbench
======================================

Name: interface_spimaster

Overview:
- SPI mode-0 master that sends one BUFFER_SIZE-bit frame to an SPI slave (MSB first) and captures the slave's reply frame in the same transfer.
- Sits on the host or bridge side of the frame-based SPI link.
- The outgoing frame carries MSGID in its top 32 bits; the caller supplies it in tx_data.
- The reply is checked against MSGID and flagged with rx_valid.

Parameters:
- BUFFER_SIZE, 64: frame length in bits; minimum 33.
- MSGID, 32'h74697277: expected header in the top 32 bits of the received frame.
- CLK_DIV, 4: length of each SCK half-period in clk cycles; minimum 4 (the slave uses a 3-stage edge synchroniser).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a transfer; sampled only in IDLE.
- tx_data  in  BUFFER_SIZE  frame to send; latched on the cycle start is accepted.
- rx_data  out  BUFFER_SIZE  last received frame; updated at done.
- rx_valid  out  1  rx_data[BUFFER_SIZE-1:BUFFER_SIZE-32]==MSGID; updated at done.
- done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- SPI_SCK  out  1  serial clock; idle low.
- SPI_SSEL  out  1  slave select, active low; idle high.
- SPI_MOSI  out  1  serial data out.
- SPI_MISO  in  1  serial data in; double-flopped before use.

Behaviour:
- Reset (async, rst_n=0) forces the state to IDLE and sets:
  - SPI_SSEL=1, SPI_SCK=0, SPI_MOSI=0;
  - busy=0, done=0, rx_valid=0, rx_data=0;
  - shift registers and counters cleared.
  - Reset mid-frame aborts immediately with no done pulse.
- States: IDLE, SETUP, HIGH, LOW, GAP. One divider counter counts 0..CLK_DIV-1 per phase. bit_cnt is $clog2(BUFFER_SIZE+1) bits wide.
- IDLE:
  - start=1 at edge k latches tx_data into tx_shift, clears bit_cnt and goes to SETUP.
  - From edge k+1: SSEL=0, busy=1, MOSI=tx_shift[MSB].
- SETUP: SCK=0 for CLK_DIV cycles, then HIGH.
- HIGH: SCK=1 for CLK_DIV cycles.
  - On the last cycle of HIGH, shift the synchronised MISO into rx_shift LSB and increment bit_cnt.
  - Then go to LOW.
- LOW: SCK=0 for CLK_DIV cycles.
  - On entry (the SCK falling edge), tx_shift shifts left with 0 fill and MOSI follows the new MSB.
  - At the end of LOW: if bit_cnt==BUFFER_SIZE, go to GAP; otherwise go to HIGH.
  - The final LOW phase is the SSEL hold time.
- Frame timing:
  - Exactly BUFFER_SIZE SCK rising edges per frame.
  - SSEL is low for CLK_DIV*(2*BUFFER_SIZE+1) cycles.
  - MOSI is 0 after the last falling edge.
- GAP entry cycle:
  - SSEL=1, done=1 for that cycle only.
  - rx_data<=rx_shift (always, whether or not the header matches).
  - rx_valid<=(rx_shift header==MSGID).
- GAP: SSEL stays high for CLK_DIV cycles, then IDLE with busy=0. The start→done latency is 1+CLK_DIV*(2*BUFFER_SIZE+1) cycles.
- start while busy is ignored and not queued.
- If start is held high, a new frame begins on the first IDLE cycle, so SSEL is high for exactly CLK_DIV+1 cycles between frames.
- tx_data changes after acceptance have no effect on the current frame.
- rx_data and rx_valid hold their value between done pulses.
- SCK, SSEL and MOSI are all registered outputs (glitch-free).

Test Plan:
- Loopback MOSI→MISO, BUFFER_SIZE=64, CLK_DIV=4, tx_data=64'h74697277_12345678, start pulse → SSEL low for 516 cycles, 64 SCK rising edges, done pulses once, rx_data=64'h74697277_12345678, rx_valid=1, busy low CLK_DIV cycles after done.
- Behavioural mode-0 slave model returning 64'h74697277_DEADBEEF (MSB valid at SSEL fall, shifts on SCK fall after a 3-cycle sync delay) → rx_data=64'h74697277_DEADBEEF, rx_valid=1; the slave received tx_data bit-exact.
- Slave model returns 64'h00000000_DEADBEEF → rx_data updated to that value, rx_valid=0, done still pulses.
- Second start pulse 100 cycles into a frame → ignored: exactly 64 SCK edges, one done. Then start held high → two back-to-back frames with SSEL high exactly 5 cycles between them.
- rst_n low at bit 20 of a frame → SSEL=1, SCK=0, busy=0 asynchronously, no done pulse, rx_data=0. Next start runs a clean full frame.
- CLK_DIV=4 vs CLK_DIV=10 with the slave model → correct data in both cases; SCK high and low phases measure exactly CLK_DIV cycles each.

Source files
------------

// File: rtl/interface_spimaster.sv
// SPI mode-0 master: shifts one BUFFER_SIZE-bit frame out MSB first while capturing the reply,
// then flags whether the reply header matches MSGID.
module interface_spimaster #(
  parameter int unsigned BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter int unsigned CLK_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   done,
  output logic                   busy,
  output logic                   SPI_SCK,
  output logic                   SPI_SSEL,
  output logic                   SPI_MOSI,
  input  logic                   SPI_MISO
);

  localparam int unsigned CntW = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned DivW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StGap} state_e;

  state_e                 state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BUFFER_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [BUFFER_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic                   miso_meta_q, miso_sync_q;
  logic                   sck_q, ssel_q, mosi_q, busy_q, done_q, rx_valid_q;
  logic [BUFFER_SIZE-1:0] rx_data_q;
  logic                   div_last, in_frame, gap_entry;

  assign div_last  = (div_q == DivW'(CLK_DIV - 1));
  assign in_frame  = (state_q == StSetup) || (state_q == StHigh) || (state_q == StLow);
  assign gap_entry = (state_q == StGap) && (div_q == '0);

  always_comb begin
    state_d    = state_q;
    div_d      = div_last ? '0 : div_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    case (state_q)
      StIdle: begin
        div_d = '0;
        if (start) begin
          tx_shift_d = tx_data;
          bit_cnt_d  = '0;
          state_d    = StSetup;
        end
      end
      StSetup: if (div_last) state_d = StHigh;
      StHigh: begin
        // Sample at the end of the high phase; the falling edge shifts the next bit out.
        if (div_last) begin
          rx_shift_d = {rx_shift_q[BUFFER_SIZE-2:0], miso_sync_q};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          tx_shift_d = tx_shift_q << 1;
          state_d    = StLow;
        end
      end
      StLow: begin
        if (div_last) state_d = (bit_cnt_q == CntW'(BUFFER_SIZE)) ? StGap : StHigh;
      end
      StGap: if (div_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      miso_meta_q <= SPI_MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  // Pin-facing outputs are flopped from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sck_q  <= (state_q == StHigh);
      ssel_q <= !in_frame;
      mosi_q <= in_frame ? tx_shift_q[BUFFER_SIZE-1] : 1'b0;
      busy_q <= (state_q != StIdle);
      done_q <= gap_entry;
      if (gap_entry) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= (rx_shift_q[BUFFER_SIZE-1 -: 32] == MSGID);
      end
    end
  end

  assign SPI_SCK  = sck_q;
  assign SPI_SSEL = ssel_q;
  assign SPI_MOSI = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_interface_spimaster.sv
// Bench for interface_spimaster: two lanes (CLK_DIV 4 and 10) share stimulus; each has a
// mode-0 slave and a frame-timeline model that is compared against the DUT every cycle.
module tb_interface_spimaster;

  localparam int N = 64;
  localparam logic [31:0] MSGID = 32'h74697277;

  logic         clk = 1'b0;
  logic         rst_n, start, mode;
  logic [N-1:0] tx_data, reply;
  int           tests = 0, fails = 0;

  always #5 clk = ~clk;

  function automatic void check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int D        = (g == 0) ? 4 : 10;
    localparam int FrameEnd = D * (2 * N + 1);
    localparam int Span     = D * (2 * N + 2);

    logic         sck, ssel, mosi, miso, busy, done, rx_valid;
    logic [N-1:0] rx_data;

    interface_spimaster #(.BUFFER_SIZE(N), .MSGID(MSGID), .CLK_DIV(D)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .tx_data (tx_data),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .done    (done),
      .busy    (busy),
      .SPI_SCK (sck),
      .SPI_SSEL(ssel),
      .SPI_MOSI(mosi),
      .SPI_MISO(miso)
    );

    // Slave sees SCK/SSEL through a 3-stage synchroniser; reply reloads while deselected.
    logic [2:0]   sck_s, ssel_s;
    logic [N-1:0] sl_tx, sl_rx;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sck_s <= '0; ssel_s <= 3'b111; sl_tx <= '0; sl_rx <= '0;
      end else begin
        sck_s  <= {sck_s[1:0], sck};
        ssel_s <= {ssel_s[1:0], ssel};
        if (ssel_s[2]) begin
          sl_tx <= reply;
          sl_rx <= '0;
        end else begin
          if (sck_s[2:1] == 2'b01) sl_rx <= {sl_rx[N-2:0], mosi};
          if (sck_s[2:1] == 2'b10) sl_tx <= sl_tx << 1;
        end
      end
    end
    assign miso = mode ? sl_tx[N-1] : mosi;

    // Model: t = clock edges since the frame was accepted.
    bit           act;
    int           t;
    logic [N-1:0] f_tx, f_exp, m_rx;
    bit           m_valid;
    logic         m_idle;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act <= 0; t <= 0; m_rx <= '0; m_valid <= 0;
      end else if ((!act || t >= Span) && start) begin
        act <= 1; t <= 0; f_tx <= tx_data; f_exp <= mode ? reply : tx_data;
      end else if (act) begin
        t <= t + 1;
        if (t + 1 == FrameEnd + 1) begin
          m_rx    <= f_exp;
          m_valid <= (f_exp[N-1 -: 32] == MSGID);
        end
      end
    end
    assign m_idle = !act || (t > Span);

    int f_rises, f_dones, f_low, done_t, run;
    bit prev_sck, prev_low;
    always @(negedge clk) begin : chk
      bit e_ssel, e_sck, e_mosi, e_busy, e_done;
      int p;
      if (rst_n) begin
        e_ssel = 1; e_sck = 0; e_mosi = 0; e_busy = 0; e_done = 0;
        if (act && t >= 1) begin
          if (t <= FrameEnd) begin
            e_ssel = 0;
            p      = (t - 1) / D;
            e_sck  = (p % 2) == 1;
            if (p / 2 < N) e_mosi = f_tx[N - 1 - p / 2];
          end
          e_busy = (t <= Span);
          e_done = (t == FrameEnd + 1);
        end
        check($sformatf("lane%0d pins{ssel,sck,mosi,busy,done,valid}", g),
              N'({ssel, sck, mosi, busy, done, rx_valid}),
              N'({e_ssel, e_sck, e_mosi, e_busy, e_done, m_valid}));
        check($sformatf("lane%0d rx_data", g), rx_data, m_rx);
        if (act && t == 0) begin
          f_rises = 0; f_dones = 0; f_low = 0; done_t = -1;
        end
        if (sck && !prev_sck) f_rises++;
        if (!ssel) f_low++;
        if (done) begin
          f_dones++;
          done_t = t;
          check($sformatf("lane%0d slave_rx", g), sl_rx, f_tx);
        end
        if (!ssel) begin
          if (!prev_low) run = 1;
          else if (sck != prev_sck) begin
            check($sformatf("lane%0d phase_len", g), N'(run), N'(D));
            run = 1;
          end else run++;
        end else if (prev_low) begin
          check($sformatf("lane%0d phase_len", g), N'(run), N'(D));
        end
        prev_sck = sck;
        prev_low = !ssel;
      end else begin
        prev_sck = 0;
        prev_low = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 4000 && !(g_lane[0].busy == 0 && g_lane[0].m_idle &&
                             g_lane[1].busy == 0 && g_lane[1].m_idle));
    check("wait_idle_in_budget", N'(n < 4000), N'(1));
  endtask

  task automatic run_frame(input logic m, input logic [N-1:0] tx, input logic [N-1:0] rep);
    @(negedge clk);
    mode = m; tx_data = tx; reply = rep; start = 1;
    @(negedge clk);
    start   = 0;
    tx_data = {$urandom, $urandom};
    wait_idle();
  endtask

  initial begin
    int n, hi;
    logic [N-1:0] tx, rep, exp;
    logic         m;
    rst_n = 0; start = 0; mode = 0; tx_data = '0; reply = '0;
    repeat (3) @(negedge clk);
    check("reset_ssel", N'(g_lane[0].ssel), N'(1));
    check("reset_sck_busy", N'({g_lane[0].sck, g_lane[0].busy, g_lane[0].mosi}), N'(0));
    check("reset_rx", g_lane[0].rx_data, '0);
    rst_n = 1;
    repeat (3) @(negedge clk);

    run_frame(0, 64'h74697277_12345678, '0);
    check("lp_rx", g_lane[0].rx_data, 64'h74697277_12345678);
    check("lp_rx_div10", g_lane[1].rx_data, 64'h74697277_12345678);
    check("lp_valid", N'(g_lane[0].rx_valid), N'(1));
    check("lp_ssel_low", N'(g_lane[0].f_low), N'(516));
    check("lp_sck_rises", N'(g_lane[0].f_rises), N'(64));
    check("lp_done_count", N'(g_lane[0].f_dones), N'(1));
    check("lp_latency", N'(g_lane[0].done_t), N'(517));
    check("lp_latency_div10", N'(g_lane[1].done_t), N'(1291));

    run_frame(1, {$urandom, $urandom}, 64'h74697277_DEADBEEF);
    check("sl_rx", g_lane[0].rx_data, 64'h74697277_DEADBEEF);
    check("sl_rx_div10", g_lane[1].rx_data, 64'h74697277_DEADBEEF);
    check("sl_valid", N'(g_lane[1].rx_valid), N'(1));

    run_frame(1, {$urandom, $urandom}, 64'h00000000_DEADBEEF);
    check("bad_hdr_rx", g_lane[0].rx_data, 64'h00000000_DEADBEEF);
    check("bad_hdr_valid", N'(g_lane[0].rx_valid), N'(0));
    check("bad_hdr_done", N'(g_lane[0].f_dones), N'(1));

    // Start pulse while busy must be dropped.
    @(negedge clk);
    mode = 1; reply = 64'h74697277_0BADF00D; tx_data = {$urandom, $urandom}; start = 1;
    @(negedge clk);
    start = 0;
    repeat (100) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_idle();
    check("ign_sck_rises", N'(g_lane[0].f_rises), N'(64));
    check("ign_done_count", N'(g_lane[0].f_dones), N'(1));

    // Held start: back-to-back frames with a CLK_DIV+1 cycle SSEL gap.
    start = 1;
    n = 0;
    while (g_lane[0].ssel && n < 2000) begin @(negedge clk); n++; end
    while (!g_lane[0].ssel && n < 4000) begin @(negedge clk); n++; end
    hi = 0;
    while (g_lane[0].ssel && n < 6000) begin @(negedge clk); hi++; n++; end
    check("b2b_gap", N'(hi), N'(5));
    start = 0;
    wait_idle();

    // Asynchronous reset mid-frame.
    @(negedge clk);
    mode = 1; reply = 64'h74697277_CAFEF00D; tx_data = {$urandom, $urandom}; start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (g_lane[0].f_rises < 20 && n < 2000) begin @(negedge clk); n++; end
    check("reach_bit20", N'(n < 2000), N'(1));
    rst_n = 0;
    #1;
    check("arst_pins", N'({g_lane[0].ssel, g_lane[0].sck, g_lane[0].busy, g_lane[0].done}),
          N'(4'b1000));
    check("arst_rx", g_lane[0].rx_data, '0);
    check("arst_div10", N'({g_lane[1].ssel, g_lane[1].sck, g_lane[1].busy}), N'(3'b100));
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_frame(1, {$urandom, $urandom}, 64'h74697277_DEADBEEF);
    check("post_rst_rx", g_lane[0].rx_data, 64'h74697277_DEADBEEF);
    check("post_rst_done", N'(g_lane[0].f_dones), N'(1));

    for (int i = 0; i < 8; i++) begin
      m   = 1'($urandom % 2);
      tx  = {($urandom % 2) ? MSGID : $urandom, $urandom};
      rep = {($urandom % 2) ? MSGID : $urandom, $urandom};
      exp = m ? rep : tx;
      run_frame(m, tx, rep);
      check("rnd_rx", g_lane[0].rx_data, exp);
      check("rnd_rx_div10", g_lane[1].rx_data, exp);
      check("rnd_valid", N'(g_lane[0].rx_valid), N'(exp[N-1 -: 32] == MSGID));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
